plic_lite: RTL

//  Minimal single-context platform-level interrupt controller for core0.

---
 rtl/plic_lite_pkg.sv | 18 +
 rtl/plic_lite_if.sv | 14 +
 rtl/plic_lite_gateway.sv | 45 ++++
 rtl/plic_lite.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/plic_lite_pkg.sv
// Shared constants and types for the single-context PLIC.
package plic_lite_pkg;

    localparam logic [21:0] PLIC_PRIO_BASE = 22'h000000;
    localparam logic [21:0] PLIC_PENDING   = 22'h001000;
    localparam logic [21:0] PLIC_ENABLE    = 22'h002000;
    localparam logic [21:0] PLIC_THRESH    = 22'h200000;
    localparam logic [21:0] PLIC_CLAIM     = 22'h200004;

    localparam int PLIC_PRIO_W = 3;
    localparam int PLIC_NSRC   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

endpackage

// File: rtl/plic_lite_if.sv
// D-bus slave port of the PLIC: request held until a one-cycle ack.
interface plic_lite_if;
    logic        req;
    logic        we;
    logic [21:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, output we, output addr, output wdata,
                    input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/plic_lite_gateway.sv
// Level gateway for one source: synchroniser, pending and in-flight flags.
module plic_lite_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic src_level,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_flight
);

    logic sync1;
    logic sync2;

    // Two-flop synchroniser for the asynchronous source level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= src_level;
            sync2 <= sync1;
        end
    end

    // Claim clear beats a same-cycle set; in_flight blocks re-arming until complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            if (claim) begin
                pending <= 1'b0;
            end else if (sync2 && !in_flight) begin
                pending <= 1'b1;
            end
            if (claim) begin
                in_flight <= 1'b1;
            end else if (complete) begin
                in_flight <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/plic_lite.sv
// Single-context PLIC: register file, priority arbiter and bus responder.
// NSRC is assumed to be a power of two so the priority window decodes cleanly.
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int NSRC   = PLIC_NSRC,
    parameter int PRIO_W = PLIC_PRIO_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src,
    plic_lite_if.slave      bus,
    output logic            irq_ext
);

    localparam int IDW = $clog2(NSRC);

    bus_state_t          state;
    bus_state_t          state_nxt;
    logic [PRIO_W-1:0]   prio [NSRC];
    logic [NSRC-1:0]     enable;
    logic [PRIO_W-1:0]   threshold;
    logic [31:0]         rdata_q;
    logic [NSRC-1:0]     pending;
    logic [NSRC-1:0]     in_flight;
    logic [NSRC-1:0]     claim_vec;
    logic [NSRC-1:0]     complete_vec;
    logic [IDW-1:0]      best_id;
    logic [PRIO_W-1:0]   best_prio;
    logic                accept;
    logic                prio_hit;
    logic [IDW-1:0]      prio_idx;
    logic                claim_hit;
    logic [31:0]         read_val;

    wire unused_bits = ^{src[0], in_flight[0], claim_vec[0], complete_vec[0]};

    assign pending[0]   = 1'b0;
    assign in_flight[0] = 1'b0;

    for (genvar g = 1; g < NSRC; g++) begin : g_gw
        plic_lite_gateway u_gw (
            .clk       (clk),
            .rst_n     (rst_n),
            .src_level (src[g]),
            .claim     (claim_vec[g]),
            .complete  (complete_vec[g]),
            .pending   (pending[g]),
            .in_flight (in_flight[g])
        );
    end

    // Arbiter: highest priority above threshold wins, ascending scan keeps lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = threshold;
        for (int i = 1; i < NSRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_id   = IDW'(i);
                best_prio = prio[i];
            end
        end
    end

    // Address decode and read mux.
    always_comb begin
        accept    = (state == IDLE) && bus.req;
        prio_idx  = bus.addr[IDW+1:2];
        prio_hit  = (bus.addr[21:IDW+2] == PLIC_PRIO_BASE[21:IDW+2]) &&
                    (bus.addr[1:0] == 2'b00);
        claim_hit = (bus.addr == PLIC_CLAIM);
        read_val  = '0;
        if (prio_hit) begin
            read_val = 32'(prio[prio_idx]);
        end else if (bus.addr == PLIC_PENDING) begin
            read_val = 32'(pending);
        end else if (bus.addr == PLIC_ENABLE) begin
            read_val = 32'(enable);
        end else if (bus.addr == PLIC_THRESH) begin
            read_val = 32'(threshold);
        end else if (claim_hit) begin
            read_val = 32'(best_id);
        end
    end

    // Claim/complete strobes to the gateways; full wdata compared so out-of-range IDs do nothing.
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 1; i < NSRC; i++) begin
            claim_vec[i]    = accept && !bus.we && claim_hit && (best_id == IDW'(i));
            complete_vec[i] = accept && bus.we && claim_hit && (bus.wdata == 32'(i));
        end
    end

    // Register file writes, performed on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            threshold <= '0;
        end else if (accept && bus.we) begin
            if (prio_hit && (prio_idx != '0)) begin
                prio[prio_idx] <= bus.wdata[PRIO_W-1:0];
            end
            if (bus.addr == PLIC_ENABLE) begin
                enable <= {bus.wdata[NSRC-1:1], 1'b0};
            end
            if (bus.addr == PLIC_THRESH) begin
                threshold <= bus.wdata[PRIO_W-1:0];
            end
        end
    end

    // Bus state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus next state: one response cycle per accepted request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data captured at acceptance, zeroed once the response cycle ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= bus.we ? 32'd0 : read_val;
        end else begin
            rdata_q <= '0;
        end
    end

    // Registered interrupt request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_ext <= 1'b0;
        end else begin
            irq_ext <= (best_id != '0);
        end
    end

    assign bus.ack   = (state == RESP);
    assign bus.rdata = rdata_q;

endmodule
